// File: rtl/controller_fsm.sv
// Instruction-sequencing controller: a Moore FSM that steps the datapath through
// MOV/ADD/CMP/AND/MVN using opcode/op latched when start is accepted.
module controller_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       bad_instr
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWrImm,
    StLoadA,
    StLoadB,
    StExec,
    StWrRd
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;
  logic       bad_q, bad_d;

  logic accept;
  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;

  assign accept     = (state_q == StWait) && start;

  // All decisions after acceptance use the captured fields, never the live inputs.
  assign is_mov_imm = (opcode_q == 3'b110) && (op_q == 2'b10);
  assign is_mov_reg = (opcode_q == 3'b110) && (op_q == 2'b00);
  assign is_add     = (opcode_q == 3'b101) && (op_q == 2'b00);
  assign is_cmp     = (opcode_q == 3'b101) && (op_q == 2'b01);
  assign is_and     = (opcode_q == 3'b101) && (op_q == 2'b10);
  assign is_mvn     = (opcode_q == 3'b101) && (op_q == 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StWait;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    bad_d    = bad_q;
    unique case (state_q)
      StWait: begin
        if (start) begin
          state_d  = StDecode;
          opcode_d = opcode;
          op_d     = op;
          bad_d    = 1'b0;
        end
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWrImm;
        end else if (is_add || is_cmp || is_and) begin
          state_d = StLoadA;
        end else if (is_mvn || is_mov_reg) begin
          state_d = StLoadB;
        end else begin
          state_d = StWait;
          bad_d   = 1'b1;
        end
      end
      StWrImm: state_d = StWait;
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StExec;
      StExec:  state_d = is_cmp ? StWait : StWrRd;
      StWrRd:  state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    waiting   = 1'b0;
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    unique case (state_q)
      StWait: waiting = 1'b1;
      StDecode: ;
      StWrImm: begin
        reg_sel = 2'b10;
        wb_sel  = 2'b10;
        w_en    = 1'b1;
      end
      StLoadA: begin
        reg_sel = 2'b10;
        en_A    = 1'b1;
      end
      StLoadB: en_B = 1'b1;
      StExec: begin
        en_status = is_cmp;
        en_C      = !is_cmp;
        sel_A     = is_mov_reg || is_mvn;
      end
      StWrRd: begin
        reg_sel = 2'b01;
        w_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bad_instr = bad_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: table of instructions with expected per-cycle output words,
// queued on issue and compared one per clock, plus reset/toggle corner sequences.
module tb_controller_fsm;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, bad_instr;
  logic [1:0] reg_sel, wb_sel;

  controller_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .op        (op),
    .waiting   (waiting),
    .reg_sel   (reg_sel),
    .wb_sel    (wb_sel),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .bad_instr (bad_instr)
  );

  always #5 clk = ~clk;

  // Word layout: {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, bad}
  localparam logic [12:0] W_WAIT = {1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [12:0] W_DEC  = 13'd0;
  localparam logic [12:0] W_IMM  = {1'b0, 2'b10, 2'b10, 8'b1000_0000};
  localparam logic [12:0] W_LA   = {1'b0, 2'b10, 2'b00, 8'b0100_0000};
  localparam logic [12:0] W_LB   = {1'b0, 2'b00, 2'b00, 8'b0010_0000};
  localparam logic [12:0] W_EX   = {1'b0, 2'b00, 2'b00, 8'b0001_0000};
  localparam logic [12:0] W_EXM  = {1'b0, 2'b00, 2'b00, 8'b0001_0100};
  localparam logic [12:0] W_ES   = {1'b0, 2'b00, 2'b00, 8'b0000_1000};
  localparam logic [12:0] W_WR   = {1'b0, 2'b01, 2'b00, 8'b1000_0000};

  typedef struct packed {
    logic [2:0]        opc;
    logic [1:0]        op;
    logic [2:0]        n;
    logic              bad;
    logic [0:5][12:0]  seq;
  } vec_t;

  vec_t          vecs [12];
  logic [12:0]   sb [$];
  logic          bad_exp;
  string         cur_name;
  int            checks;
  int            failures;

  function automatic vec_t mk(input logic [2:0] opc, input logic [1:0] opv,
                              input logic [2:0] n, input logic bad,
                              input logic [0:5][12:0] seq);
    vec_t v;
    v.opc = opc;
    v.op  = opv;
    v.n   = n;
    v.bad = bad;
    v.seq = seq;
    return v;
  endfunction

  task automatic tick();
    logic [12:0] exp_w, act_w;
    int          strobes;
    @(posedge clk);
    #1;
    exp_w = (sb.size() > 0) ? sb.pop_front() : (W_WAIT | {12'd0, bad_exp});
    act_w = {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
             bad_instr};
    checks++;
    if (act_w !== exp_w) begin
      failures++;
      $display("FAIL %s outputs: got %b expected %b", cur_name, act_w, exp_w);
    end
    strobes = int'(w_en) + int'(en_A) + int'(en_B) + int'(en_C) + int'(en_status);
    checks++;
    if (strobes > 1) begin
      failures++;
      $display("FAIL %s onehot: got %0d strobes expected <=1", cur_name, strobes);
    end
  endtask

  task automatic issue(input int idx, input bit held);
    vec_t        v;
    logic [12:0] w;
    v        = vecs[idx];
    cur_name = $sformatf("vec%0d_%b_%b", idx, v.opc, v.op);
    opcode   = v.opc;
    op       = v.op;
    start    = 1'b1;
    for (int i = 0; i < int'(v.n); i++) begin
      w = v.seq[i];
      if (i == int'(v.n) - 1 && v.bad) w = w | 13'd1;
      sb.push_back(w);
    end
    bad_exp = v.bad;
    for (int i = 0; i < int'(v.n); i++) begin
      tick();
      if (i == 0 && !held) start = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bad_exp  = 1'b0;
    vecs[0]  = mk(3'b110, 2'b10, 3, 1'b0, {W_DEC, W_IMM, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[1]  = mk(3'b101, 2'b00, 6, 1'b0, {W_DEC, W_LA, W_LB, W_EX, W_WR, W_WAIT});
    vecs[2]  = mk(3'b101, 2'b10, 6, 1'b0, {W_DEC, W_LA, W_LB, W_EX, W_WR, W_WAIT});
    vecs[3]  = mk(3'b101, 2'b01, 5, 1'b0, {W_DEC, W_LA, W_LB, W_ES, W_WAIT, W_WAIT});
    vecs[4]  = mk(3'b101, 2'b11, 5, 1'b0, {W_DEC, W_LB, W_EXM, W_WR, W_WAIT, W_WAIT});
    vecs[5]  = mk(3'b110, 2'b00, 5, 1'b0, {W_DEC, W_LB, W_EXM, W_WR, W_WAIT, W_WAIT});
    vecs[6]  = mk(3'b111, 2'b00, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[7]  = mk(3'b000, 2'b11, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[8]  = mk(3'b110, 2'b01, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[9]  = mk(3'b100, 2'b10, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[10] = mk(3'b110, 2'b11, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});
    vecs[11] = mk(3'b111, 2'b11, 2, 1'b1, {W_DEC, W_WAIT, W_WAIT, W_WAIT, W_WAIT, W_WAIT});

    // Reset held two edges with start asserted: start must be ignored.
    cur_name = "reset";
    rst_n    = 1'b0;
    start    = 1'b1;
    opcode   = 3'b110;
    op       = 2'b10;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();

    // Table sweep; undefined codes leave bad_instr set through idle cycles until the next start.
    issue(0, 1'b0);
    issue(1, 1'b0);
    issue(2, 1'b0);
    issue(3, 1'b0);
    issue(4, 1'b0);
    issue(5, 1'b0);
    issue(6, 1'b0);
    cur_name = "bad_sticky";
    tick();
    tick();
    issue(0, 1'b0);
    for (int k = 7; k < 12; k++) begin
      issue(k, 1'b0);
      cur_name = "bad_idle";
      tick();
      issue(5, 1'b0);
    end

    // CMP then MVN with start held: no idle cycle between them.
    issue(3, 1'b1);
    issue(4, 1'b0);
    tick();

    // Reset during LOAD_B of an AND aborts it with no later w_en.
    cur_name = "rst_mid_and";
    opcode   = 3'b101;
    op       = 2'b10;
    start    = 1'b1;
    sb.push_back(W_DEC);
    sb.push_back(W_LA);
    sb.push_back(W_LB);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n   = 1'b0;
    bad_exp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    // ADD with a stray start mid-sequence and opcode/op flipped to CMP during EXEC.
    cur_name = "add_toggle";
    opcode   = 3'b101;
    op       = 2'b00;
    start    = 1'b1;
    sb.push_back(W_DEC);
    sb.push_back(W_LA);
    sb.push_back(W_LB);
    sb.push_back(W_EX);
    sb.push_back(W_WR);
    sb.push_back(W_WAIT);
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op     = 2'b01;
    opcode = 3'b101;
    tick();
    opcode = 3'b111;
    tick();
    tick();
    tick();

    // Bad flag set then reset clears it.
    issue(6, 1'b0);
    cur_name = "rst_clears_bad";
    rst_n    = 1'b0;
    bad_exp  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
